booth_radix4_seq_mul: RTL and testbench
=======================================

Name: booth_radix4_seq_mul

Overview:
- Parametrised sequential multiplier using the radix-4 (modified Booth) algorithm.
- Supports signed (two's complement) and unsigned operands, selected per operation.
- Retires two multiplier bits per clock and uses a start/busy/done handshake.
- Serves as the general-purpose multi-cycle multiplier in the datapath, replacing fixed-width, fixed-mode, free-running sequential Booth units.

Parameters:
- N, 8, operand width in bits. Must be even and ≥ 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = M and Q are two's complement; 0 = unsigned. Sampled with start.
- M  input  N  multiplicand; sampled with start.
- Q  input  N  multiplier; sampled with start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; Prod valid and final.
- Prod  output  2N  product: signed result if signed_mode was 1, otherwise unsigned.

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, Prod=0.
  - Internal accumulator, operand registers and counter are cleared.
  - Reset has priority over every other input, including mid-RUN; an aborted operation produces no done.
- Operand extension at capture:
  - M and Q are extended to W = N+2 bits.
  - Sign-extended if signed_mode=1, zero-extended if 0.
  - This makes unsigned full-range operands correct under Booth recoding.
- States:
  - IDLE: busy=0. On start=1, capture the extended M and Q, clear the accumulator, load the counter with W/2 = N/2+1, and go to RUN.
  - RUN: one radix-4 step per cycle.
    - Examine the triplet {Q[1], Q[0], q_-1}, with q_-1 = 0 initially.
    - Add 0, ±M or ±2M into the upper W+1-bit accumulator half.
    - Arithmetic-shift the combined {acc, Q, q_-1} right by 2.
    - Decrement the counter.
    - When the step with counter = 1 completes, register Prod as the low 2N bits of the result and go to DONE.
  - DONE: done=1 for exactly this cycle, busy=1. Go to IDLE unconditionally on the next edge.
- Internal widths:
  - Accumulator is W+1 bits, so 2M never overflows.
  - Partial-product arithmetic is two's complement throughout.
  - The final 2N bits are exact for all input combinations in both modes.
- Latency:
  - Start accepted at edge k; done is high in the cycle following edge k + N/2 + 1.
  - Example for N=8: done is visible after edge k+5.
  - Throughput is one result per N/2+3 cycles.
- Prod hold rules:
  - Prod changes only on entry to DONE (and on reset).
  - It holds its value through IDLE until the next result.
- start handling:
  - start while busy=1 (RUN or DONE) is ignored; no queuing.
  - Changes to M, Q or signed_mode after capture have no effect on the running operation.
  - start held high continuously yields back-to-back operations, each re-sampling inputs in IDLE.
- Corner cases that must be exact:
  - Most-negative operands in signed mode, e.g. -2^(N-1) × -2^(N-1) = 2^(2N-2).
  - All-ones operands in unsigned mode: (2^N-1)^2.
  - Zero operands.
- done and busy are registered outputs with no combinational path from inputs.

Test Plan:
- N=8, rst held 2 cycles then released, start idle → busy=0, done=0, Prod=0x0000.
- N=8, signed_mode=0, M=255, Q=255, start 1 cycle → done pulses exactly 5 edges after the start edge; Prod=0xFE01 (65025); busy high for 6 cycles.
- N=8, signed_mode=1:
  - M=0x80, Q=0x80 → Prod=0x4000.
  - M=0xFF, Q=0x7F → Prod=0xFF81 (-127).
  - M=0x05, Q=0xFD → Prod=0xFFF1 (-15).
- N=8, start M=12, Q=10 (unsigned), then start again with M=3, Q=3 on a RUN cycle → single done; Prod=120; the second request is dropped; Prod holds 120 in IDLE.
- N=8, rst=1 asserted during RUN cycle 2 of M=200, Q=100 → next cycle busy=0, Prod=0, no done pulse; a following start with M=7, Q=6 → Prod=42.
- N=16 and N=4 regression, 1000 random operands per mode with start held high → every done matches the reference product (signed/unsigned) with correct latency N/2+1.

Source files
------------

// File: rtl/booth_radix4_seq_mul_if.sv
// Handshake and operand/result bundle for the radix-4 Booth sequential multiplier.
interface booth_radix4_seq_mul_if #(
  parameter int unsigned N = 8
) ();
  logic           start;
  logic           signed_mode;
  logic [N-1:0]   M;
  logic [N-1:0]   Q;
  logic           busy;
  logic           done;
  logic [2*N-1:0] Prod;

  modport master (output start, signed_mode, M, Q, input busy, done, Prod);
  modport slave  (input start, signed_mode, M, Q, output busy, done, Prod);
endinterface

// File: rtl/booth_radix4_seq_mul.sv
// Sequential radix-4 (modified Booth) multiplier, signed or unsigned per operation,
// retiring two multiplier bits per clock behind a start/busy/done handshake.
module booth_radix4_seq_mul #(
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_radix4_seq_mul_if.slave bus
);

  localparam int unsigned W     = N + 2;
  localparam int unsigned A     = W + 1;
  localparam int unsigned STEPS = W / 2;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [A-1:0]  acc;
  logic [A-1:0]  mcand;
  logic [W-1:0]  qr;
  logic          q_m1;
  logic [CW-1:0] cnt;

  logic [A-1:0]  pp_c;
  logic [A-1:0]  sum_c;

  // Booth recoding of {Q[1], Q[0], q_-1} into 0, +-M, +-2M and accumulate.
  always_comb begin
    pp_c = '0;
    case ({qr[1:0], q_m1})
      3'b001, 3'b010: pp_c = mcand;
      3'b011:         pp_c = mcand << 1;
      3'b100:         pp_c = -(mcand << 1);
      3'b101, 3'b110: pp_c = -mcand;
      default:        pp_c = '0;
    endcase
    sum_c = acc + pp_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      qr       <= '0;
      q_m1     <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Prod <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Extension to W bits keeps full-range unsigned operands correct.
            mcand    <= bus.signed_mode ? {{3{bus.M[N-1]}}, bus.M} : {3'b000, bus.M};
            qr       <= bus.signed_mode ? {{2{bus.Q[N-1]}}, bus.Q} : {2'b00, bus.Q};
            acc      <= '0;
            q_m1     <= 1'b0;
            cnt      <= CW'(STEPS);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc  <= {{2{sum_c[A-1]}}, sum_c[A-1:2]};
          qr   <= {sum_c[1:0], qr[W-1:2]};
          q_m1 <= qr[1];
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            // Low 2N bits of the shifted {acc, qr}.
            bus.Prod <= {sum_c[N-1:0], qr[W-1:2]};
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Scoreboard bench for booth_radix4_seq_mul at N=8 (directed) and N=16/N=4 (random).
module tb_booth_radix4_seq_mul;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  logic [7:0]  q4[$];

  booth_radix4_seq_mul_if #(.N(8))  if8  ();
  booth_radix4_seq_mul_if #(.N(16)) if16 ();
  booth_radix4_seq_mul_if #(.N(4))  if4  ();

  booth_radix4_seq_mul #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  booth_radix4_seq_mul #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  booth_radix4_seq_mul #(.N(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref8(input logic sm, input logic [7:0] m, input logic [7:0] q);
    logic [15:0] me, qe;
    me = sm ? {{8{m[7]}}, m} : {8'h00, m};
    qe = sm ? {{8{q[7]}}, q} : {8'h00, q};
    return 16'(me * qe);
  endfunction

  // One 1-cycle start on the N=8 unit; reports done latency, busy cycles and result.
  task automatic do_op8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                        output int lat, output int bcnt, output logic [15:0] p, output logic seen);
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = sm; if8.M = m; if8.Q = q;
    q8.push_back(ref8(sm, m, q));
    @(posedge clk); #1;
    if8.start = 1'b0;
    bcnt = if8.busy ? 1 : 0;
    lat = 0; seen = 1'b0; p = '0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      lat++;
      if (if8.busy) bcnt++;
      if (if8.done) begin seen = 1'b1; p = if8.Prod; break; end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (if8.busy) bcnt++; else break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (if8.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if8.busy); end
    checks++; if (if8.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", if8.done); end
    checks++; if (if8.Prod !== 16'h0000) begin errors++; $display("FAIL reset_prod got %h want 0000", if8.Prod); end
  endtask

  task automatic test_unsigned_max();
    int lat, bcnt; logic [15:0] p, e; logic seen;
    do_op8(1'b0, 8'hFF, 8'hFF, lat, bcnt, p, seen);
    e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    checks++; if (!seen || lat != 5) begin errors++; $display("FAIL umax_latency got %0d seen %b want 5", lat, seen); end
    checks++; if (p !== e || e !== 16'hFE01) begin errors++; $display("FAIL umax_prod got %h want %h", p, e); end
    checks++; if (bcnt != 6) begin errors++; $display("FAIL umax_busy_cycles got %0d want 6", bcnt); end
  endtask

  task automatic test_signed();
    logic [7:0] ms[3] = '{8'h80, 8'hFF, 8'h05};
    logic [7:0] qs[3] = '{8'h80, 8'h7F, 8'hFD};
    logic [15:0] ws[3] = '{16'h4000, 16'hFF81, 16'hFFF1};
    int lat, bcnt; logic [15:0] p, e; logic seen;
    for (int i = 0; i < 3; i++) begin
      do_op8(1'b1, ms[i], qs[i], lat, bcnt, p, seen);
      e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
      checks++;
      if (!seen || p !== e || e !== ws[i]) begin
        errors++; $display("FAIL signed_%0d got %h seen %b want %h", i, p, seen, ws[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones; logic [15:0] p, e;
    dones = 0; p = '0;
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.M = 8'd12; if8.Q = 8'd10;
    q8.push_back(ref8(1'b0, 8'd12, 8'd10));
    @(posedge clk); #1 if8.start = 1'b0;
    @(negedge clk);
    if8.start = 1'b1; if8.M = 8'd3; if8.Q = 8'd3;
    @(posedge clk); #1 if8.start = 1'b0;
    if (if8.done) begin dones++; p = if8.Prod; end
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (if8.done) begin dones++; p = if8.Prod; end
    end
    e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dones); end
    checks++; if (p !== e) begin errors++; $display("FAIL ignore_prod got %0d want %0d", p, e); end
    checks++; if (if8.Prod !== 16'd120 || if8.busy !== 1'b0) begin
      errors++; $display("FAIL ignore_hold got %0d busy %b want 120 busy 0", if8.Prod, if8.busy);
    end
  endtask

  task automatic test_reset_abort();
    int dones, lat, bcnt; logic [15:0] p, e; logic seen;
    @(negedge clk);
    if8.start = 1'b1; if8.signed_mode = 1'b0; if8.M = 8'd200; if8.Q = 8'd100;
    @(posedge clk); #1 if8.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl got busy %b done %b want 0 0", if8.busy, if8.done);
    end
    checks++; if (if8.Prod !== 16'h0000) begin errors++; $display("FAIL abort_prod got %h want 0000", if8.Prod); end
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (if8.done) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", dones); end
    do_op8(1'b0, 8'd7, 8'd6, lat, bcnt, p, seen);
    e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    checks++; if (!seen || p !== e || lat != 5) begin
      errors++; $display("FAIL abort_next got %0d lat %0d want %0d lat 5", p, lat, e);
    end
  endtask

  task automatic test_random_n16();
    int lat, g; logic seen; logic [15:0] m, q; logic [31:0] e, got;
    if16.start = 1'b1;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        g = 0;
        while (if16.busy && g < 20) begin @(negedge clk); g++; end
        m = 16'($urandom); q = 16'($urandom);
        if16.signed_mode = mode[0]; if16.M = m; if16.Q = q;
        if (mode[0]) q16.push_back(32'($signed({{16{m[15]}}, m}) * $signed({{16{q[15]}}, q})));
        else         q16.push_back({16'h0000, m} * {16'h0000, q});
        @(posedge clk); #1;
        lat = 0; seen = 1'b0; got = '0;
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          lat++;
          if (if16.done) begin seen = 1'b1; got = if16.Prod; break; end
        end
        e = (q16.size() > 0) ? q16.pop_front() : 32'hxxxxxxxx;
        checks++;
        if (!seen || lat != 9 || got !== e) begin
          errors++; $display("FAIL rand16 mode %0d m %h q %h got %h lat %0d want %h lat 9", mode, m, q, got, lat, e);
        end
      end
    end
    if16.start = 1'b0;
  endtask

  task automatic test_random_n4();
    int lat, g; logic seen; logic [3:0] m, q; logic [7:0] e, got;
    if4.start = 1'b1;
    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        g = 0;
        while (if4.busy && g < 20) begin @(negedge clk); g++; end
        m = 4'($urandom); q = 4'($urandom);
        if4.signed_mode = mode[0]; if4.M = m; if4.Q = q;
        if (mode[0]) q4.push_back(8'($signed({{4{m[3]}}, m}) * $signed({{4{q[3]}}, q})));
        else         q4.push_back({4'h0, m} * {4'h0, q});
        @(posedge clk); #1;
        lat = 0; seen = 1'b0; got = '0;
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); #1;
          lat++;
          if (if4.done) begin seen = 1'b1; got = if4.Prod; break; end
        end
        e = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
        checks++;
        if (!seen || lat != 3 || got !== e) begin
          errors++; $display("FAIL rand4 mode %0d m %h q %h got %h lat %0d want %h lat 3", mode, m, q, got, lat, e);
        end
      end
    end
    if4.start = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1;
    if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.M = '0;  if8.Q = '0;
    if16.start = 1'b0; if16.signed_mode = 1'b0; if16.M = '0; if16.Q = '0;
    if4.start = 1'b0;  if4.signed_mode = 1'b0;  if4.M = '0;  if4.Q = '0;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_ignore_start();
    test_reset_abort();
    test_random_n16();
    test_random_n4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
